calc_ctrl: RTL

Front-end controller for the button/switch calculator. Synchronizes and debounces the five push-buttons, turns them into single-cycle command pulses, and sequences the ALU/accumulator datapath:
- latches the operation select and the switch operand;
- issues one accumulator load or clear per press.

It sits between the board pins and the decoder/ALU/accumulator datapath, replacing the raw button wiring.

---
 rtl/calc_pkg.sv | 8 +
 rtl/btn_debounce.sv | 46 ++++
 rtl/calc_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator front-end controller.
// Contents: FSM state enum and the bit positions of the select buttons inside alu_sel.
package calc_pkg;
    typedef enum logic [2:0] {IDLE, CAPTURE, EXECUTE, CLEAR, WAIT_REL} state_t;
    localparam int SEL_L = 2;
    localparam int SEL_C = 1;
    localparam int SEL_R = 0;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, debouncer and rising-edge pulse for one raw button.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_btn       raw button input
//   o_level     debounced stable level
//   o_rise      one-cycle pulse after the stable level rises
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    logic r_s1, r_s2, r_stable, r_stable_d, r_rise;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_rise     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_s1       <= i_btn;
            r_s2       <= r_s1;
            r_stable_d <= r_stable;
            r_rise     <= r_stable & ~r_stable_d;
            // The counter only runs while the synchronized level disagrees; any agreement restarts it.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CMAX) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign o_level = r_stable;
    assign o_rise  = r_rise;
endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: button/switch front-end that sequences the calculator ALU/accumulator datapath.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   btnc, btnl, btnr        raw operation-select buttons
//   btnu                    raw clear button
//   btnd                    raw execute button
//   sw[15:0]                raw operand switches
//   alu_sel[2:0]            latched {btnl,btnc,btnr} debounced levels
//   op2_q[15:0]             latched synchronized switch operand
//   acc_load, acc_clr       one-cycle accumulator load / clear strobes
//   busy                    FSM not in IDLE
//   op_count[CNT_W-1:0]     executed loads since reset or last clear
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btnc,
    input  logic             btnl,
    input  logic             btnr,
    input  logic             btnu,
    input  logic             btnd,
    input  logic [15:0]      sw,
    output logic [2:0]       alu_sel,
    output logic [15:0]      op2_q,
    output logic             acc_load,
    output logic             acc_clr,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    logic w_lvl_c, w_lvl_l, w_lvl_r, w_lvl_u, w_lvl_d, w_clr_p, w_exe_p;
    logic [15:0] r_sw1, r_sw2, r_op2;
    logic [2:0] r_alu_sel;
    logic [CNT_W-1:0] r_op_count;
    state_t r_state, w_state_nx;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (.clk(clk), .rst_n(rst_n), .i_btn(btnc), .o_level(w_lvl_c), .o_rise());
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (.clk(clk), .rst_n(rst_n), .i_btn(btnl), .o_level(w_lvl_l), .o_rise());
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (.clk(clk), .rst_n(rst_n), .i_btn(btnr), .o_level(w_lvl_r), .o_rise());
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (.clk(clk), .rst_n(rst_n), .i_btn(btnu), .o_level(w_lvl_u), .o_rise(w_clr_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (.clk(clk), .rst_n(rst_n), .i_btn(btnd), .o_level(w_lvl_d), .o_rise(w_exe_p));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw1 <= '0;
            r_sw2 <= '0;
        end else begin
            r_sw1 <= sw;
            r_sw2 <= r_sw1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    // Presses seen outside IDLE fall through untouched, so they are dropped rather than queued.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:     w_state_nx = w_clr_p ? CLEAR : (w_exe_p ? CAPTURE : IDLE);
            CAPTURE:  w_state_nx = EXECUTE;
            EXECUTE:  w_state_nx = WAIT_REL;
            CLEAR:    w_state_nx = WAIT_REL;
            WAIT_REL: w_state_nx = (w_lvl_u || w_lvl_d) ? WAIT_REL : IDLE;
            default:  w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        acc_load = (r_state == EXECUTE);
        acc_clr  = (r_state == CLEAR);
        busy     = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_sel  <= '0;
            r_op2      <= '0;
            r_op_count <= '0;
        end else begin
            if (r_state == CAPTURE) begin
                r_alu_sel[SEL_L] <= w_lvl_l;
                r_alu_sel[SEL_C] <= w_lvl_c;
                r_alu_sel[SEL_R] <= w_lvl_r;
                r_op2            <= r_sw2;
            end
            if (r_state == CLEAR)        r_op_count <= '0;
            else if (r_state == EXECUTE) r_op_count <= r_op_count + 1'b1;
        end
    end

    assign alu_sel  = r_alu_sel;
    assign op2_q    = r_op2;
    assign op_count = r_op_count;
endmodule
